// File: rtl/line_clear_engine_pkg.sv
// Shared types and board dimensions for the line-clear engine.
// Imported by the top level and by the row buffer.
`timescale 1ns/1ps
package line_clear_engine_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef logic [2:0] cell_t;     // 0 = empty cell
    typedef logic [4:0] row_idx_t;
    typedef logic [3:0] col_idx_t;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RD_START   = 4'd1,
        S_RD_DATA    = 4'd2,
        S_DECIDE     = 4'd3,
        S_WR_START   = 4'd4,
        S_WR_DATA    = 4'd5,
        S_FILL_START = 4'd6,
        S_FILL_DATA  = 4'd7,
        S_DONE       = 4'd8
    } clear_state_t;

    function automatic logic cell_occupied(input cell_t c);
        return c != 3'd0;
    endfunction

endpackage

// File: rtl/line_clear_engine_row_buffer.sv
// One board row held as a shift register: cells enter at the tail while
// reading and leave from the head while writing; tracks "every cell occupied".
`timescale 1ns/1ps
module line_clear_engine_row_buffer
    import line_clear_engine_pkg::*;
#(
    parameter int COLS = BOARD_COLS
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  shift_en,
    input  cell_t shift_in,
    input  logic  full_init,
    input  logic  full_acc,
    output cell_t shift_out,
    output logic  full
);

    cell_t cells_q [COLS];
    cell_t cells_d [COLS];
    logic  full_q;
    logic  full_d;

    // Next contents: shift toward the head, new cell at the tail.
    always_comb begin
        cells_d = cells_q;
        if (shift_en) begin
            for (int i = 0; i < COLS - 1; i++) begin
                cells_d[i] = cells_q[i + 1];
            end
            cells_d[COLS - 1] = shift_in;
        end else begin
            cells_d = cells_q;
        end
    end

    // Full flag is primed at the row start and ANDed with each incoming cell.
    always_comb begin
        full_d = full_q;
        if (full_init) begin
            full_d = 1'b1;
        end else if (full_acc) begin
            full_d = full_q & cell_occupied(shift_in);
        end else begin
            full_d = full_q;
        end
    end

    // Buffer and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COLS; i++) begin
                cells_q[i] <= 3'd0;
            end
            full_q <= 1'b0;
        end else begin
            cells_q <= cells_d;
            full_q  <= full_d;
        end
    end

    assign shift_out = cells_q[0];
    assign full      = full_q;

endmodule

// File: rtl/line_clear_engine.sv
// Scans the playfield bottom-up, removes full rows by copying survivors
// downward, zero-fills the vacated top rows and reports the lines removed.
`timescale 1ns/1ps
module line_clear_engine
    import line_clear_engine_pkg::*;
#(
    parameter int ROWS     = BOARD_ROWS,
    parameter int COLS     = BOARD_COLS,
    parameter int ROW_BASE = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
    output logic       mem_start,
    output logic       mem_write_enable,
    output logic       mem_cont,
    output logic [5:0] mem_addr,
    output logic [2:0] mem_wdata,
    input  logic [2:0] mem_rdata
);

    localparam row_idx_t   LAST_ROW = row_idx_t'(ROWS - 1);
    localparam col_idx_t   LAST_COL = col_idx_t'(COLS - 1);
    localparam logic [5:0] ROWS_W   = 6'(ROWS);
    localparam logic [5:0] BASE_W   = 6'(ROW_BASE);

    clear_state_t state_q, state_d;
    row_idx_t     src_q, src_d;
    row_idx_t     dst_q, dst_d;
    col_idx_t     col_q, col_d;
    logic [4:0]   lines_q, lines_d;

    logic         buf_shift_s;
    logic         buf_full_init_s;
    logic         buf_full_acc_s;
    cell_t        buf_shift_in_s;
    cell_t        buf_head_s;
    logic         buf_full_s;
    logic         last_col_s;
    logic [4:0]   lines_inc_s;

    line_clear_engine_row_buffer #(
        .COLS (COLS)
    ) u_row_buffer (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (buf_shift_s),
        .shift_in  (buf_shift_in_s),
        .full_init (buf_full_init_s),
        .full_acc  (buf_full_acc_s),
        .shift_out (buf_head_s),
        .full      (buf_full_s)
    );

    assign buf_shift_in_s = (state_q == S_RD_DATA) ? mem_rdata : 3'd0;
    assign last_col_s     = (col_q == LAST_COL);
    assign lines_inc_s    = ({1'b0, lines_q} < ROWS_W) ? (lines_q + 5'd1) : lines_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= LAST_ROW;
            dst_q   <= LAST_ROW;
            col_q   <= 4'd0;
            lines_q <= 5'd0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            col_q   <= col_d;
            lines_q <= lines_d;
        end
    end

    // Next state, row/column bookkeeping and row buffer control.
    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        col_d           = col_q;
        lines_d         = lines_q;
        buf_shift_s     = 1'b0;
        buf_full_init_s = 1'b0;
        buf_full_acc_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_RD_START;
                    lines_d = 5'd0;
                    src_d   = LAST_ROW;
                    dst_d   = LAST_ROW;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_START: begin
                buf_full_init_s = 1'b1;
                col_d           = 4'd0;
                state_d         = S_RD_DATA;
            end
            S_RD_DATA: begin
                buf_shift_s    = 1'b1;
                buf_full_acc_s = 1'b1;
                if (last_col_s) begin
                    col_d   = 4'd0;
                    state_d = S_DECIDE;
                end else begin
                    col_d   = col_q + 4'd1;
                end
            end
            S_DECIDE: begin
                if (buf_full_s) begin
                    lines_d = lines_inc_s;
                    if (src_q == 5'd0) begin
                        state_d = S_FILL_START;
                    end else begin
                        src_d   = src_q - 5'd1;
                        state_d = S_RD_START;
                    end
                end else if (src_q != dst_q) begin
                    state_d = S_WR_START;
                end else if (src_q == 5'd0) begin
                    state_d = (lines_q != 5'd0) ? S_FILL_START : S_DONE;
                end else begin
                    src_d   = src_q - 5'd1;
                    dst_d   = dst_q - 5'd1;
                    state_d = S_RD_START;
                end
            end
            S_WR_START: begin
                col_d   = 4'd0;
                state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                buf_shift_s = 1'b1;
                if (last_col_s) begin
                    col_d = 4'd0;
                    // dst sits above src here, so it is never 0 on this path
                    dst_d = (dst_q != 5'd0) ? (dst_q - 5'd1) : dst_q;
                    if (src_q == 5'd0) begin
                        state_d = (lines_q != 5'd0) ? S_FILL_START : S_DONE;
                    end else begin
                        src_d   = src_q - 5'd1;
                        state_d = S_RD_START;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            S_FILL_START: begin
                col_d   = 4'd0;
                state_d = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                if (last_col_s) begin
                    col_d = 4'd0;
                    if (dst_q == 5'd0) begin
                        state_d = S_DONE;
                    end else begin
                        dst_d   = dst_q - 5'd1;
                        state_d = S_FILL_START;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the state register.
    always_comb begin
        busy             = 1'b0;
        done             = 1'b0;
        mem_start        = 1'b0;
        mem_write_enable = 1'b0;
        mem_cont         = 1'b0;
        mem_addr         = 6'd0;
        mem_wdata        = 3'd0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_RD_START: begin
                busy      = 1'b1;
                mem_start = 1'b1;
                mem_addr  = BASE_W + {1'b0, src_q};
            end
            S_RD_DATA, S_FILL_DATA: begin
                busy     = 1'b1;
                mem_cont = 1'b1;
            end
            S_DECIDE: begin
                busy = 1'b1;
            end
            S_WR_START, S_FILL_START: begin
                busy             = 1'b1;
                mem_start        = 1'b1;
                mem_write_enable = 1'b1;
                mem_addr         = BASE_W + {1'b0, dst_q};
            end
            S_WR_DATA: begin
                busy      = 1'b1;
                mem_cont  = 1'b1;
                mem_wdata = buf_head_s;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign lines_cleared = lines_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed scoreboard bench for line_clear_engine with a start/cont
// row-protocol memory model; the monitor checks each completed clear.
`timescale 1ns/1ps
module tb_line_clear_engine;

    localparam int R = 20;
    localparam int C = 10;

    typedef logic [2:0] cells_t [C];
    typedef struct {
        string      name;
        logic [4:0] lines;
        int         cycles;
        int         writes;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clear_req;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;
    logic       mem_start;
    logic       mem_write_enable;
    logic       mem_cont;
    logic [5:0] mem_addr;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;
    int proto_err   = 0;
    exp_t sb [$];

    cells_t init_b [R];
    cells_t exp_b  [R];

    line_clear_engine dut (
        .clk              (clk),
        .reset            (reset),
        .clear_req        (clear_req),
        .busy             (busy),
        .done             (done),
        .lines_cleared    (lines_cleared),
        .mem_start        (mem_start),
        .mem_write_enable (mem_write_enable),
        .mem_cont         (mem_cont),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Playfield memory: row latched on start, column advances on cont.
    logic [2:0] mem [0:63][0:15];
    logic [5:0] lat_row = 6'd0;
    logic       lat_we  = 1'b0;
    logic [3:0] lat_col = 4'd0;
    logic       load_now = 1'b0;

    always @(posedge clk) begin
        if (load_now) begin
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    mem[r][c] <= init_b[r][c];
        end else if (mem_start) begin
            lat_row <= mem_addr;
            lat_we  <= mem_write_enable;
            lat_col <= 4'd0;
        end else if (mem_cont) begin
            if (lat_we) mem[lat_row][lat_col] <= mem_wdata;
            lat_col <= lat_col + 4'd1;
        end
    end
    assign mem_rdata = mem[lat_row][lat_col];

    function automatic logic [31:0] pack_cells(input cells_t c);
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < C; i++) p[3*i +: 3] = c[i];
        return p;
    endfunction

    function automatic logic [31:0] mem_row(input int r);
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < C; i++) p[3*i +: 3] = mem[r][i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on each done.
    int   busy_cnt  = 0;
    int   write_cnt = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mem_start && mem_cont) proto_err++;
        if (mem_wdata != 3'd0 && !(mem_cont && lat_we)) proto_err++;
        if (done && !busy) proto_err++;
        if (!busy) begin
            busy_cnt  = 0;
            write_cnt = 0;
        end else begin
            busy_cnt++;
            if (mem_start && mem_write_enable) write_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done with no request pending, expected none");
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_lines"},  32'(lines_cleared), 32'(mon_e.lines));
                    chk({mon_e.name, "_cycles"}, 32'(busy_cnt),      32'(mon_e.cycles));
                    chk({mon_e.name, "_writes"}, 32'(write_cnt),     32'(mon_e.writes));
                    for (int r = 0; r < R; r++)
                        chk($sformatf("%s_row%0d", mon_e.name, r), mem_row(r), pack_cells(exp_b[r]));
                end
            end
        end
    end

    task automatic clear_boards();
        for (int r = 0; r < R; r++) begin
            init_b[r] = '{default: 3'd0};
            exp_b[r]  = '{default: 3'd0};
        end
    endtask

    task automatic load_mem();
        load_now = 1'b1;
        @(posedge clk);
        #1;
        load_now = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: done not seen within %0d cycles, expected done", name, budget);
        end
    endtask

    task automatic push_exp(input string name, input logic [4:0] lines, input int cycles, input int writes);
        exp_t e;
        e.name   = name;
        e.lines  = lines;
        e.cycles = cycles;
        e.writes = writes;
        sb.push_back(e);
    endtask

    task automatic run_op(input string name, input logic [4:0] lines, input int cycles, input int writes);
        push_exp(name, lines, cycles, writes);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_done(name, 2000);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Rows 16 and 18 full; 15, 17, 19 survive with holes.
    task automatic build_two_gaps();
        clear_boards();
        init_b[19] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
        init_b[18] = '{default: 3'd6};
        init_b[17] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd6, 3'd6, 3'd6, 3'd6};
        init_b[16] = '{default: 3'd3};
        init_b[15] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0};
        exp_b[19]  = init_b[19];
        exp_b[18]  = init_b[17];
        exp_b[17]  = init_b[15];
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        clear_req = 1'b0;
        clear_boards();
        repeat (3) @(negedge clk);
        chk("rst_busy",      32'(busy),             32'd0);
        chk("rst_done",      32'(done),             32'd0);
        chk("rst_lines",     32'(lines_cleared),    32'd0);
        chk("rst_mem_start", 32'(mem_start),        32'd0);
        chk("rst_mem_cont",  32'(mem_cont),         32'd0);
        chk("rst_mem_we",    32'(mem_write_enable), 32'd0);
        chk("rst_mem_addr",  32'(mem_addr),         32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata),        32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Empty board: 20 reads plus done, no writes.
        clear_boards();
        load_mem();
        run_op("empty", 5'd0, 241, 0);

        // Row 18's pattern has no empty cell, so both bottom rows go.
        clear_boards();
        init_b[19] = '{default: 3'd5};
        init_b[18] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
        load_mem();
        run_op("bottom_two", 5'd2, 461, 20);

        build_two_gaps();
        load_mem();
        run_op("two_gaps", 5'd2, 450, 19);

        // Last column empty: not full, nothing moves.
        clear_boards();
        init_b[19] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};
        exp_b[19]  = init_b[19];
        load_mem();
        run_op("col9_hole", 5'd0, 241, 0);

        // Top row full: cleared at src=0, then a single fill of row 0.
        clear_boards();
        init_b[0]  = '{default: 3'd2};
        init_b[19] = '{3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0};
        exp_b[19]  = init_b[19];
        load_mem();
        run_op("top_full", 5'd1, 252, 1);

        // Reset in the middle of the first copy.
        build_two_gaps();
        load_mem();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (mem_cont && lat_we) found = 1'b1;
        end
        chk("reach_wr_data", 32'(found), 32'd1);
        chk("pre_reset_lines", 32'(lines_cleared), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy",      32'(busy),          32'd0);
        chk("midrst_mem_start", 32'(mem_start),     32'd0);
        chk("midrst_mem_cont",  32'(mem_cont),      32'd0);
        chk("midrst_lines",     32'(lines_cleared), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        build_two_gaps();
        load_mem();
        run_op("after_reset", 5'd2, 450, 19);

        // Request held high: accepted again straight after done; pulses while busy ignored.
        clear_boards();
        load_mem();
        push_exp("held_a", 5'd0, 241, 0);
        clear_req = 1'b1;
        wait_done("held_a", 2000);
        push_exp("held_b", 5'd0, 241, 0);
        @(negedge clk);
        @(negedge clk);
        chk("held_reaccept_busy", 32'(busy), 32'd1);
        clear_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
        end
        wait_done("held_b", 2000);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (30) @(negedge clk);
        chk("idle_after_done_pulse", 32'(busy), 32'd0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("protocol_errors",  32'(proto_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
